seg_display_scan: RTL and testbench

- Downstream stage of the stopwatch digit counters.
- Consumes the four BCD digits: d1 (minutes), d2 (tens of seconds), d3 (seconds), d4 (tenths).
- Time-multiplexes them onto one common-anode 4-digit seven-segment display.
- Contains the refresh divider, digit-select rotation, per-frame digit snapshot, anti-ghosting guard and the segment decoder.

---
 rtl/seg_display_scan_pkg.sv | 24 ++
 rtl/seg_display_scan_seg7_decode.sv | 26 ++
 rtl/seg_display_scan.sv | 104 ++++++++++
 tb/tb_seg_display_scan.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
// Shared constants and types for the stopwatch seven-segment scanner.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg_display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    // Bit i set: decimal point lit while digit slot i is scanned.
    localparam logic [NUM_DIGITS-1:0] DP_MASK = 4'b0101;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg_display_scan_seg7_decode.sv
// Combinational BCD to active-high seven-segment pattern; non-BCD codes show a dash.
module seg7_decode
    import seg_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit common-anode multiplexer with per-frame digit snapshot and anti-ghost guard.
// Optional macro LEADING_ZERO_BLANK_EN suppresses a leading zero minutes digit.
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       mclock,
    input  logic       rst_n,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD    = CW'(GUARD_CYCLES);
    localparam logic [6:0]    SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic          DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [3:0]    AN_OFF   = {4{AN_ACTIVE_LOW}};

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          div_last;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic [6:0]    lit_seg;
    logic          lit_dp;
    logic [3:0]    an_onehot;

    seg7_decode u_decode (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        div_last  = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_last ? '0 : div_cnt_q + CW'(1);
        idx_d     = div_last ? idx_q + 2'd1 : idx_q;
        // Latch new digits only as the last slot ends so a frame is never mixed.
        shadow_d  = (div_last && idx_q == 2'd3) ? {d1, d2, d3, d4} : shadow_q;

        cur_digit = '0;
        an_onehot = '0;
        case (idx_q)
            2'd0: begin cur_digit = shadow_q[15:12]; an_onehot = 4'b1000; end
            2'd1: begin cur_digit = shadow_q[11:8];  an_onehot = 4'b0100; end
            2'd2: begin cur_digit = shadow_q[7:4];   an_onehot = 4'b0010; end
            default: begin cur_digit = shadow_q[3:0]; an_onehot = 4'b0001; end
        endcase

        lit_seg = dec_seg;
        lit_dp  = DP_MASK[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == 2'd0 && cur_digit == 4'd0) begin
            lit_seg = '0;
            lit_dp  = 1'b0;
        end
`endif

        seg_d = SEG_ACTIVE_LOW ? ~lit_seg : lit_seg;
        dp_d  = SEG_ACTIVE_LOW ? ~lit_dp  : lit_dp;
        if (div_cnt_q >= GUARD && !blank)
            an_d = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
        else
            an_d = AN_OFF;
    end

    always_ff @(posedge mclock or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            an_q      <= AN_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: a cycle-count model queues expected outputs.
module tb_seg_display_scan;

    localparam int R = 4;
    localparam int G = 1;

    logic       mclock = 1'b0;
    logic       rst_n;
    logic [3:0] d1, d2, d3, d4;
    logic       blank;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 mclock = ~mclock;

    seg_display_scan #(
        .REFRESH_DIV    (R),
        .GUARD_CYCLES   (G),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .mclock (mclock),
        .rst_n  (rst_n),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3),
        .d4     (d4),
        .blank  (blank),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned mcnt     = 0;
    logic [15:0] mshadow  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] hi_pattern(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Model: output after edge n+1 reflects slot (n/R)%4, position n%R.
    int unsigned m_div, m_slot;
    logic [3:0]  m_digit, m_sel;
    logic [6:0]  m_lit;
    logic        m_ldp;
    exp_t        m_e;

    always @(posedge mclock) begin
        if (!rst_n) begin
            mcnt    = 0;
            mshadow = '0;
        end else begin
            m_div   = mcnt % R;
            m_slot  = (mcnt / R) % 4;
            m_digit = mshadow[4*(3-m_slot) +: 4];
            m_sel   = 4'b1000 >> m_slot;
            m_lit   = hi_pattern(m_digit);
            m_ldp   = (m_slot == 0) || (m_slot == 2);
`ifdef LEADING_ZERO_BLANK_EN
            if (m_slot == 0 && m_digit == 4'd0) begin
                m_lit = '0;
                m_ldp = 1'b0;
            end
`endif
            m_e.an  = (m_div >= G && !blank) ? ~m_sel : 4'b1111;
            m_e.seg = ~m_lit;
            m_e.dp  = ~m_ldp;
            sb_q.push_back(m_e);
            if (m_div == R-1 && m_slot == 3)
                mshadow = {d1, d2, d3, d4};
            mcnt++;
        end
    end

    always @(negedge rst_n) begin
        sb_q.delete();
        mcnt    = 0;
        mshadow = '0;
    end

    exp_t c_e;
    always @(negedge mclock) begin
        if (rst_n && sb_q.size() > 0) begin
            c_e = sb_q.pop_front();
            chk("sb_an",  32'(an),  32'(c_e.an));
            chk("sb_seg", 32'(seg), 32'(c_e.seg));
            chk("sb_dp",  32'(dp),  32'(c_e.dp));
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge mclock);
    endtask

    task automatic wait_pos(input int unsigned slot, input int unsigned div);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge mclock);
            if ((mcnt / R) % 4 == slot && mcnt % R == div) found = 1'b1;
        end
        chk("wait_pos", 32'(found), 32'd1);
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d);
        d1 = a; d2 = b; d3 = c; d4 = d;
    endtask

    initial begin
        rst_n = 1'b0;
        blank = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        cycles(3);
        chk("rst_an",  32'(an),  32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_dp",  32'(dp),  32'd1);

        rst_n = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        cycles(1);
        chk("rel1_an", 32'(an), 32'b1111);
        cycles(1);
        chk("rel2_an", 32'(an), 32'b0111);
        cycles(40);

        // Snapshot coherence: swap digits during slot 1 of a frame.
        set_digits(4'd5, 4'd9, 4'd5, 4'd9);
        cycles(20);
        wait_pos(1, 1);
        set_digits(4'd6, 4'd0, 4'd0, 4'd0);
        cycles(40);

        // Blank for 10 cycles mid-slot.
        wait_pos(2, 2);
        blank = 1'b1;
        cycles(1);
        chk("blank_an", 32'(an), 32'b1111);
        cycles(9);
        blank = 1'b0;
        cycles(24);

        // Invalid digit on d2 shows a dash.
        set_digits(4'd1, 4'hC, 4'd7, 4'd8);
        cycles(40);

        // Leading zero on the minutes digit.
        set_digits(4'd0, 4'd3, 4'd9, 4'd2);
        cycles(40);

        // Reset asserted mid-slot.
        wait_pos(1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_an",  32'(an),  32'h0000000F);
        chk("midrst_seg", 32'(seg), 32'h0000007F);
        chk("midrst_dp",  32'(dp),  32'd1);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        chk("rerel1_an", 32'(an), 32'b1111);
        cycles(1);
        chk("rerel2_an", 32'(an), 32'b0111);
        cycles(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
